// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master Wishbone classic round-robin arbiter
// Optional bus-timeout watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 14,
  parameter int SEL_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m0_cyc,
  input  logic                     m0_stb,
  input  logic                     m0_we,
  input  logic [ADDRESS_WIDTH-1:0] m0_adr,
  input  logic [DATA_WIDTH-1:0]    m0_dat_mosi,
  input  logic [SEL_WIDTH-1:0]     m0_sel,
  output logic                     m0_ack,
  input  logic                     m1_cyc,
  input  logic                     m1_stb,
  input  logic                     m1_we,
  input  logic [ADDRESS_WIDTH-1:0] m1_adr,
  input  logic [DATA_WIDTH-1:0]    m1_dat_mosi,
  input  logic [SEL_WIDTH-1:0]     m1_sel,
  output logic                     m1_ack,
  output logic [DATA_WIDTH-1:0]    m_dat_miso,
  output logic                     s_cyc,
  output logic                     s_stb,
  output logic                     s_we,
  output logic [ADDRESS_WIDTH-1:0] s_adr,
  output logic [DATA_WIDTH-1:0]    s_dat_mosi,
  output logic [SEL_WIDTH-1:0]     s_sel,
  input  logic                     s_ack,
  input  logic [DATA_WIDTH-1:0]    s_dat_miso,
  output logic [1:0]               grant,
  output logic                     timeout_flag,
  input  logic                     timeout_clr
);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1} state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t r_state;
  state_t w_next;
  logic   r_last;
  logic   w_req0;
  logic   w_req1;
  logic   w_own_stb;
  logic   w_tmo_ack;

  assign w_req0 = m0_cyc & m0_stb;
  assign w_req1 = m1_cyc & m1_stb;

  // Release between transfers lets the other master in even while CYC is held.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) w_next = r_last ? ST_OWN0 : ST_OWN1;
        else if (w_req0)      w_next = ST_OWN0;
        else if (w_req1)      w_next = ST_OWN1;
      end
      ST_OWN0: if (!m0_cyc || (!m0_stb && w_req1)) w_next = ST_IDLE;
      ST_OWN1: if (!m1_cyc || (!m1_stb && w_req0)) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_next == ST_OWN0) r_last <= 1'b0;
      if (r_state == ST_IDLE && w_next == ST_OWN1) r_last <= 1'b1;
    end
  end

  always_comb begin
    s_cyc      = 1'b0;
    w_own_stb  = 1'b0;
    s_we       = 1'b0;
    s_adr      = '0;
    s_dat_mosi = '0;
    s_sel      = '0;
    grant      = 2'b00;
    case (r_state)
      ST_OWN0: begin
        s_cyc      = m0_cyc;
        w_own_stb  = m0_stb;
        s_we       = m0_we;
        s_adr      = m0_adr;
        s_dat_mosi = m0_dat_mosi;
        s_sel      = m0_sel;
        grant      = 2'b01;
      end
      ST_OWN1: begin
        s_cyc      = m1_cyc;
        w_own_stb  = m1_stb;
        s_we       = m1_we;
        s_adr      = m1_adr;
        s_dat_mosi = m1_dat_mosi;
        s_sel      = m1_sel;
        grant      = 2'b10;
      end
      default: ;
    endcase
  end

  // The synthetic ACK withdraws the strobe so the slave never sees the aborted beat.
  assign s_stb      = w_own_stb & ~w_tmo_ack;
  assign m0_ack     = (r_state == ST_OWN0) & (s_ack | w_tmo_ack);
  assign m1_ack     = (r_state == ST_OWN1) & (s_ack | w_tmo_ack);
  assign m_dat_miso = w_tmo_ack ? {DATA_WIDTH{1'b1}} : s_dat_miso;

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  logic       r_timeout_flag;

  assign w_tmo_ack    = (r_state != ST_IDLE) && (r_tmo_cnt == TMO_LIMIT);
  assign timeout_flag = r_timeout_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt      <= 8'd0;
      r_timeout_flag <= 1'b0;
    end else begin
      if (w_tmo_ack || (w_next != r_state) || !w_own_stb || s_ack)
        r_tmo_cnt <= 8'd0;
      else
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      if (w_tmo_ack)        r_timeout_flag <= 1'b1;
      else if (timeout_clr) r_timeout_flag <= 1'b0;
    end
  end
`else
  logic w_unused_tmo;

  assign w_tmo_ack    = 1'b0;
  assign timeout_flag = 1'b0;
  assign w_unused_tmo = timeout_clr ^ (^TMO_LIMIT);
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - randomized self-checking bench for wb_arbiter2
// Timeout scenarios run when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter2;

  localparam int DW  = 32;
  localparam int AW  = 14;
  localparam int SW  = 4;
  localparam int TMO = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_cyc, m0_stb, m0_we, m0_ack;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat_mosi;
  logic [SW-1:0] m0_sel;
  logic          m1_cyc, m1_stb, m1_we, m1_ack;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat_mosi;
  logic [SW-1:0] m1_sel;
  logic [DW-1:0] m_dat_miso;
  logic          s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_mosi, s_dat_miso;
  logic [SW-1:0] s_sel;
  logic [1:0]    grant;
  logic          timeout_flag, timeout_clr;

  always #5 clk = ~clk;

  wb_arbiter2 #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_mosi(m0_dat_mosi), .m0_sel(m0_sel), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_mosi(m1_dat_mosi), .m1_sel(m1_sel), .m1_ack(m1_ack),
    .m_dat_miso(m_dat_miso),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_mosi(s_dat_mosi), .s_sel(s_sel), .s_ack(s_ack), .s_dat_miso(s_dat_miso),
    .grant(grant), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: current owner (-1 none), last winner, stall length, sticky flag
  int own, last, stall;
  bit flag;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic mcyc(input int n); return (n == 0) ? m0_cyc : m1_cyc; endfunction
  function automatic logic mstb(input int n); return (n == 0) ? m0_stb : m1_stb; endfunction
  function automatic logic mwe(input int n);  return (n == 0) ? m0_we  : m1_we;  endfunction
  function automatic logic [AW-1:0] madr(input int n); return (n == 0) ? m0_adr : m1_adr; endfunction
  function automatic logic [DW-1:0] mdat(input int n); return (n == 0) ? m0_dat_mosi : m1_dat_mosi; endfunction
  function automatic logic [SW-1:0] msel(input int n); return (n == 0) ? m0_sel : m1_sel; endfunction

  function automatic bit model_tmo();
    return TMO_EN && (own >= 0) && (stall == TMO);
  endfunction

  function automatic bit model_sstb();
    return (own >= 0) && mstb(own) && !model_tmo();
  endfunction

  task automatic model_check();
    bit tmo;
    tmo = model_tmo();
    check_val("grant", grant, (own < 0) ? 0 : ((own == 0) ? 1 : 2));
    check_val("s_cyc", s_cyc, (own < 0) ? 0 : mcyc(own));
    check_val("s_stb", s_stb, model_sstb());
    check_val("s_we", s_we, (own < 0) ? 0 : mwe(own));
    check_val("s_adr", s_adr, (own < 0) ? 0 : madr(own));
    check_val("s_dat_mosi", s_dat_mosi, (own < 0) ? 0 : mdat(own));
    check_val("s_sel", s_sel, (own < 0) ? 0 : msel(own));
    check_val("m0_ack", m0_ack, (own == 0) && (s_ack || tmo));
    check_val("m1_ack", m1_ack, (own == 1) && (s_ack || tmo));
    check_val("m_dat_miso", m_dat_miso, tmo ? 64'hFFFF_FFFF : s_dat_miso);
    check_val("timeout_flag", timeout_flag, flag);
  endtask

  task automatic model_step();
    bit tmo, r0, r1, oreq;
    int nxt;
    tmo = model_tmo();
    if (reset) begin
      own = -1; last = 1; stall = 0; flag = 0;
      return;
    end
    r0 = m0_cyc && m0_stb;
    r1 = m1_cyc && m1_stb;
    if (own < 0) begin
      if (r0 && r1)  nxt = (last == 1) ? 0 : 1;
      else if (r0)   nxt = 0;
      else if (r1)   nxt = 1;
      else           nxt = -1;
    end else begin
      oreq = (own == 0) ? r1 : r0;
      nxt = (!mcyc(own) || (!mstb(own) && oreq)) ? -1 : own;
    end
    if (tmo || nxt != own || own < 0 || !mstb(own) || s_ack) stall = 0;
    else stall++;
    if (tmo) flag = 1;
    else if (timeout_clr) flag = 0;
    if (own < 0 && nxt >= 0) last = nxt;
    own = nxt;
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_mosi = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_mosi = '0; m1_sel = '0;
    s_ack = 0; s_dat_miso = '0; timeout_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    settle();
    advance();
    settle();
    check_val("rst_grant", grant, 0);
    check_val("rst_s_cyc", s_cyc, 0);
    check_val("rst_acks", {m0_ack, m1_ack}, 0);
    check_val("rst_flag", timeout_flag, 0);
    reset = 0;
    advance();
  endtask

  initial begin
    int xfers[2];
    bit ack_seen[2];
    int prev_grant, last_owner_grant;
    own = -1; last = 1; stall = 0; flag = 0;
    reset = 1;
    idle_inputs();
    #1;

    // single m0 read, slave acks after two wait cycles
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 14'h0010; m0_sel = 4'hF;
    settle(); check_val("t1_req_grant", grant, 2'b00); advance();
    settle(); check_val("t1_grant", grant, 2'b01); check_val("t1_adr", s_adr, 14'h0010); advance();
    settle(); check_val("t1_wait_ack", m0_ack, 0); advance();
    s_ack = 1; s_dat_miso = 32'h12345678;
    settle();
    check_val("t1_ack", m0_ack, 1);
    check_val("t1_data", m_dat_miso, 32'h12345678);
    check_val("t1_m1_ack", m1_ack, 0);
    advance();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    settle(); check_val("t1_ack_pulse", m0_ack, 0); advance();
    settle(); check_val("t1_idle", grant, 2'b00); advance();

    // simultaneous requests from reset: m0 first, then handover via stb low
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 14'h0123;
    settle(); advance();
    s_ack = 1;
    settle(); check_val("t2_first", grant, 2'b01); check_val("t2_ack0", m0_ack, 1); advance();
    s_ack = 0; m0_stb = 0;
    settle(); check_val("t2_hold", grant, 2'b01); advance();
    settle(); check_val("t2_gap", grant, 2'b00); advance();
    settle(); check_val("t2_second", grant, 2'b10); check_val("t2_adr", s_adr, 14'h0123); advance();
    m0_cyc = 0; s_ack = 1;
    settle(); check_val("t2_ack1", m1_ack, 1); check_val("t2_no_ack0", m0_ack, 0); advance();
    idle_inputs();
    settle(); advance();

    // continuous requests from both: grants must alternate
    do_reset();
    xfers[0] = 0; xfers[1] = 0; ack_seen[0] = 0; ack_seen[1] = 0;
    prev_grant = 0; last_owner_grant = 2;
    for (int c = 0; c < 200 && (xfers[0] < 4 || xfers[1] < 4); c++) begin
      m0_cyc = (xfers[0] < 4); m0_stb = m0_cyc && !ack_seen[0];
      m1_cyc = (xfers[1] < 4); m1_stb = m1_cyc && !ack_seen[1];
      s_ack = model_sstb();
      settle();
      if (grant != 0 && prev_grant == 0 && xfers[0] < 4 && xfers[1] < 4) begin
        check_val("t3_alternate", grant, (last_owner_grant == 1) ? 2 : 1);
        last_owner_grant = grant;
      end
      prev_grant = grant;
      ack_seen[0] = m0_ack; ack_seen[1] = m1_ack;
      xfers[0] += m0_ack; xfers[1] += m1_ack;
      advance();
    end
    check_val("t3_xfers0", xfers[0], 4);
    check_val("t3_xfers1", xfers[1], 4);
    idle_inputs();
    settle(); advance();
    settle(); advance();

    // m1 aborts by dropping cyc mid-stall
    do_reset();
    m1_cyc = 1; m1_stb = 1;
    settle(); advance();
    settle(); check_val("t4_grant", grant, 2'b10); advance();
    settle(); advance();
    m1_cyc = 0;
    settle(); check_val("t4_abort_ack", m1_ack, 0); advance();
    settle();
    check_val("t4_s_cyc", s_cyc, 0);
    check_val("t4_grant_idle", grant, 2'b00);
    check_val("t4_no_ack", m1_ack, 0);
    m1_stb = 0;
    advance();

`ifdef WB_ARB_TIMEOUT_EN
    // slave never acks: watchdog terminates after TMO stall cycles
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    settle(); advance();
    for (int k = 0; k <= TMO; k++) begin
      settle();
      check_val("t5_tmo_ack", m0_ack, (k == TMO));
      if (k == TMO) begin
        check_val("t5_tmo_data", m_dat_miso, 32'hFFFF_FFFF);
        check_val("t5_tmo_stb", s_stb, 0);
      end
      advance();
    end
    m0_cyc = 0; m0_stb = 0;
    for (int k = 0; k < 3; k++) begin
      settle(); check_val("t5_flag_sticky", timeout_flag, 1); advance();
    end
    timeout_clr = 1;
    settle(); check_val("t5_flag_before_clr", timeout_flag, 1); advance();
    timeout_clr = 0;
    settle(); check_val("t5_flag_cleared", timeout_flag, 0); advance();
`else
    // no watchdog: a stall persists without any synthetic ACK
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    settle(); advance();
    for (int k = 0; k < 20; k++) begin
      settle(); check_val("t5_no_tmo_ack", m0_ack, 0); check_val("t5_no_flag", timeout_flag, 0); advance();
    end
    m0_cyc = 0; m0_stb = 0;
    settle(); advance();
`endif

    // reset asserted during an m1 stall
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 14'h2AAA; m1_dat_mosi = 32'hCAFEF00D; m1_sel = 4'h5;
    for (int k = 0; k < 12; k++) begin
      settle(); advance();
    end
    reset = 1;
    settle(); advance();
    settle();
    check_val("t6_grant", grant, 2'b00);
    check_val("t6_s_bus", {s_cyc, s_stb, s_we, s_adr, s_sel}, 0);
    check_val("t6_s_dat", s_dat_mosi, 0);
    check_val("t6_flag", timeout_flag, 0);
    check_val("t6_ack", m1_ack, 0);
    reset = 0;
    idle_inputs();
    advance();

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) m0_cyc = $urandom_range(0, 4) != 0;
      if ($urandom_range(0, 3) == 0) m1_cyc = $urandom_range(0, 4) != 0;
      m0_stb = $urandom_range(0, 2) != 0;
      m1_stb = $urandom_range(0, 2) != 0;
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_adr = AW'($urandom); m1_adr = AW'($urandom);
      m0_dat_mosi = $urandom; m1_dat_mosi = $urandom;
      m0_sel = SW'($urandom); m1_sel = SW'($urandom);
      s_dat_miso = $urandom;
      timeout_clr = $urandom_range(0, 7) == 0;
      reset = $urandom_range(0, 199) == 0;
      s_ack = (model_sstb() && $urandom_range(0, 2) == 0) || ($urandom_range(0, 15) == 0);
      settle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
